resp_tx_sequencer: RTL and testbench

RESP_TX_SEQUENCER -- requirements
Module: resp_tx_sequencer

---
 rtl/resp_tx_sequencer_pkg.sv | 18 +
 rtl/resp_tx_sequencer_if.sv | 29 ++
 rtl/resp_tx_sequencer_pulse_hold_cnt.sv | 34 +++
 rtl/resp_tx_sequencer.sv | 155 +++++++++++++++
 tb/tb_resp_tx_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/resp_tx_sequencer_pkg.sv
// Shared system package for the response/TX sequencing path.
// Holds the sequencer FSM state encoding and the default timing constants
// (Data_Sync hold length, TX_Busy acknowledge timeout, timeout counter width).
package resp_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    HOLD      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } tx_state_e;

  localparam int unsigned HOLD_CYCLES_DEF = 16;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;
  localparam int unsigned ACK_CNT_WIDTH   = 8;

endpackage

// File: rtl/resp_tx_sequencer_if.sv
// Bus bundle between the system controller / UART TX path and the response
// sequencer.
//   master : controller + UART side (drives read/ALU results and TX_Busy)
//   slave  : sequencer side (drives the TX byte, its valid level and status)
interface resp_tx_sequencer_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ALU_OUT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]    RdData;
  logic                     RdData_Valid;
  logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
  logic                     ALU_OUT_VALID;
  logic                     TX_Busy;
  logic [DATA_WIDTH-1:0]    TX_P_DATA;
  logic                     TX_DATA_VALID;
  logic                     Resp_Busy;
  logic                     Overrun;
  logic                     Tx_Err;

  modport master (
    output RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID, TX_Busy,
    input  TX_P_DATA, TX_DATA_VALID, Resp_Busy, Overrun, Tx_Err
  );

  modport slave (
    input  RdData, RdData_Valid, ALU_OUT, ALU_OUT_VALID, TX_Busy,
    output TX_P_DATA, TX_DATA_VALID, Resp_Busy, Overrun, Tx_Err
  );
endinterface

// File: rtl/resp_tx_sequencer_pulse_hold_cnt.sv
// pulse_hold_cnt: small up-counter used for interval timing.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   load  : clear the count (start a new interval)
//   en    : advance the count by one; saturates at all-ones, never wraps
//   done  : high while the current edge is the LIMIT-th counted edge since load
module pulse_hold_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // Compare one ahead so the owner can act on the same edge that completes
  // the interval.
  assign cnt_next = {1'b0, cnt} + (WIDTH + 1)'(1);
  assign done     = (cnt_next >= (WIDTH + 1)'(LIMIT));
endmodule

// File: rtl/resp_tx_sequencer.sv
// resp_tx_sequencer: serialises register-read and ALU results into bytes for
// the UART TX path, holding each byte's valid level long enough for the slow
// domain Data_Sync to capture it, then waiting for TX_Busy to rise and fall.
//   REF_CLK : system clock
//   RST     : synchronous active-low reset
//   bus     : slave side of resp_tx_sequencer_if
//             in : RdData/RdData_Valid, ALU_OUT/ALU_OUT_VALID, TX_Busy
//             out: TX_P_DATA, TX_DATA_VALID, Resp_Busy, Overrun, Tx_Err
module resp_tx_sequencer
  import resp_tx_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input logic                REF_CLK,
  input logic                RST,
  resp_tx_sequencer_if.slave bus
);
  localparam int unsigned HOLD_CNT_W = $clog2(HOLD_CYCLES + 1);

  tx_state_e                state;
  logic [ALU_OUT_WIDTH-1:0] buffer;
  logic [1:0]               count;
  logic [DATA_WIDTH-1:0]    tx_p_data;
  logic                     tx_data_valid;
  logic                     resp_busy;
  logic                     overrun;
  logic                     tx_err;

  logic hold_load, hold_en, hold_done;
  logic ack_load, ack_en, ack_done;
  logic strobe_any, strobe_both;

  assign strobe_any  = bus.RdData_Valid | bus.ALU_OUT_VALID;
  assign strobe_both = bus.RdData_Valid & bus.ALU_OUT_VALID;

  // Hold interval starts on the ARM->HOLD edge; timeout starts on HOLD->WAIT_ACK.
  assign hold_load = (state == ARM) && !bus.TX_Busy;
  assign hold_en   = (state == HOLD);
  assign ack_load  = (state == HOLD) && hold_done;
  assign ack_en    = (state == WAIT_ACK);

  pulse_hold_cnt #(
    .WIDTH (HOLD_CNT_W),
    .LIMIT (HOLD_CYCLES)
  ) u_hold_cnt (
    .clk   (REF_CLK),
    .rst_n (RST),
    .load  (hold_load),
    .en    (hold_en),
    .done  (hold_done)
  );

  pulse_hold_cnt #(
    .WIDTH (ACK_CNT_WIDTH),
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_cnt (
    .clk   (REF_CLK),
    .rst_n (RST),
    .load  (ack_load),
    .en    (ack_en),
    .done  (ack_done)
  );

  always_ff @(posedge REF_CLK) begin
    if (!RST) begin
      state         <= IDLE;
      buffer        <= '0;
      count         <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      resp_busy     <= 1'b0;
      overrun       <= 1'b0;
      tx_err        <= 1'b0;
    end else begin
      // In IDLE only the losing half of a simultaneous pair is dropped;
      // elsewhere every strobe is dropped.
      overrun <= (state == IDLE) ? strobe_both : strobe_any;
      tx_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.RdData_Valid) begin
            buffer    <= ALU_OUT_WIDTH'(bus.RdData);
            count     <= 2'd1;
            tx_p_data <= bus.RdData;
            resp_busy <= 1'b1;
            state     <= ARM;
          end else if (bus.ALU_OUT_VALID) begin
            buffer    <= bus.ALU_OUT;
            count     <= 2'd2;
            tx_p_data <= bus.ALU_OUT[DATA_WIDTH-1:0];
            resp_busy <= 1'b1;
            state     <= ARM;
          end
        end

        ARM: begin
          tx_p_data <= buffer[DATA_WIDTH-1:0];
          if (!bus.TX_Busy) begin
            tx_data_valid <= 1'b1;
            state         <= HOLD;
          end
        end

        HOLD: begin
          if (hold_done) begin
            tx_data_valid <= 1'b0;
            state         <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (bus.TX_Busy) begin
            state <= WAIT_DONE;
          end else if (ack_done) begin
            tx_err    <= 1'b1;
            buffer    <= '0;
            count     <= '0;
            resp_busy <= 1'b0;
            state     <= IDLE;
          end
        end

        WAIT_DONE: begin
          if (!bus.TX_Busy) begin
            if (count == 2'd1) begin
              count     <= '0;
              resp_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              // Remaining byte moves down so ARM always sends the low byte.
              count     <= count - 2'd1;
              buffer    <= buffer >> DATA_WIDTH;
              tx_p_data <= buffer[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
              state     <= ARM;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX_P_DATA     = tx_p_data;
  assign bus.TX_DATA_VALID = tx_data_valid;
  assign bus.Resp_Busy     = resp_busy;
  assign bus.Overrun       = overrun;
  assign bus.Tx_Err        = tx_err;
endmodule

// File: tb/tb_resp_tx_sequencer.sv
// Bench for resp_tx_sequencer: each frame is described by a timeline of
// expected per-cycle outputs derived from the byte-level rules (latency of two
// edges to valid, fixed hold length, acknowledge/timeout windows), with the
// UART TX_Busy response scripted from that same timeline.
module tb_resp_tx_sequencer;
  localparam int HOLD = 16;
  localparam int ACK  = 255;
  localparam int MAXL = 512;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  resp_tx_sequencer_if #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) bus ();

  resp_tx_sequencer #(
    .DATA_WIDTH    (8),
    .ALU_OUT_WIDTH (16),
    .HOLD_CYCLES   (HOLD),
    .ACK_TIMEOUT   (ACK)
  ) dut (
    .REF_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Relative edge 0 samples the strobe. pre_busy: TX_Busy high for edges
  // [0,pre_busy). ack_lat/busy_len: UART raises busy ack_lat edges after valid
  // drops and keeps it busy_len edges. stray_at/rst_at: -1 for none.
  task automatic run_frame(input bit rv, input logic [7:0] rd, input bit av,
                           input logic [15:0] alu, input int pre_busy,
                           input int ack_lat, input int busy_len, input bit no_ack,
                           input int stray_at, input int rst_at, input string name);
    bit   v_e [MAXL];
    bit   rb_e[MAXL];
    bit   er_e[MAXL];
    bit   ov_e[MAXL];
    bit   bz  [MAXL];
    int   dat_e[MAXL];
    logic [7:0] bq[$];
    int t, e, d, fin, len;

    for (int k = 0; k < MAXL; k++) begin
      v_e[k] = 1'b0; rb_e[k] = 1'b0; er_e[k] = 1'b0; ov_e[k] = 1'b0;
      bz[k] = 1'b0; dat_e[k] = -1;
    end
    if (rv) bq.push_back(rd);
    else begin
      bq.push_back(alu[7:0]);
      bq.push_back(alu[15:8]);
    end

    for (int k = 0; k < pre_busy; k++) bz[k] = 1'b1;
    t   = (pre_busy > 1) ? pre_busy : 1;
    fin = 0;
    for (int i = 0; i < bq.size(); i++) begin
      e = t + HOLD;
      for (int k = t; k < e; k++) v_e[k] = 1'b1;
      if (no_ack) begin
        fin = e + ACK;
        er_e[fin] = 1'b1;
        for (int k = t; k < MAXL; k++) dat_e[k] = int'(bq[i]);
        break;
      end
      for (int k = e + ack_lat; k < e + ack_lat + busy_len; k++) bz[k] = 1'b1;
      d = e + ack_lat + busy_len;
      if (i == bq.size() - 1) begin
        fin = d;
        for (int k = t; k < MAXL; k++) dat_e[k] = int'(bq[i]);
      end else begin
        for (int k = t; k < d; k++) dat_e[k] = int'(bq[i]);
        t = d + 1;
      end
    end
    for (int k = 0; k < fin; k++) rb_e[k] = 1'b1;
    ov_e[0] = rv && av;
    if (stray_at > 0) ov_e[stray_at] = 1'b1;

    len = fin + 24;
    if (rst_at >= 0) begin
      len = rst_at + 60;
      for (int k = rst_at; k < MAXL; k++) begin
        v_e[k] = 1'b0; rb_e[k] = 1'b0; er_e[k] = 1'b0; ov_e[k] = 1'b0;
        bz[k] = 1'b0; dat_e[k] = 0;
      end
    end

    for (int k = 0; k < len; k++) begin
      bus.TX_Busy       = bz[k];
      bus.RdData_Valid  = 1'b0;
      bus.ALU_OUT_VALID = 1'b0;
      rst               = 1'b1;
      if (k == 0) begin
        bus.RdData_Valid  = rv;
        bus.RdData        = rd;
        bus.ALU_OUT_VALID = av;
        bus.ALU_OUT       = alu;
      end
      if (k == stray_at) begin
        bus.RdData_Valid  = 1'b1;
        bus.RdData        = 8'($urandom);
        bus.ALU_OUT_VALID = 1'($urandom_range(0, 1));
        bus.ALU_OUT       = 16'($urandom);
      end
      if (k == rst_at) begin
        rst               = 1'b0;
        bus.RdData_Valid  = 1'b1;
        bus.ALU_OUT_VALID = 1'b1;
      end
      tick();
      chk($sformatf("%s valid@%0d", name, k), 16'(bus.TX_DATA_VALID), 16'(v_e[k]));
      chk($sformatf("%s busy@%0d", name, k), 16'(bus.Resp_Busy), 16'(rb_e[k]));
      chk($sformatf("%s txerr@%0d", name, k), 16'(bus.Tx_Err), 16'(er_e[k]));
      chk($sformatf("%s overrun@%0d", name, k), 16'(bus.Overrun), 16'(ov_e[k]));
      if (dat_e[k] >= 0)
        chk($sformatf("%s data@%0d", name, k), 16'(bus.TX_P_DATA), 16'(dat_e[k]));
    end
    bus.TX_Busy       = 1'b0;
    bus.RdData_Valid  = 1'b0;
    bus.ALU_OUT_VALID = 1'b0;
    rst               = 1'b1;
  endtask

  initial begin
    int kind;
    int pre, al, bl, st;
    bit na;

    rst               = 1'b0;
    bus.RdData        = 8'hFF;
    bus.RdData_Valid  = 1'b1;
    bus.ALU_OUT       = 16'hFFFF;
    bus.ALU_OUT_VALID = 1'b1;
    bus.TX_Busy       = 1'b0;
    repeat (3) tick();
    chk("reset data", 16'(bus.TX_P_DATA), 16'h0000);
    chk("reset valid", 16'(bus.TX_DATA_VALID), 16'h0000);
    chk("reset busy", 16'(bus.Resp_Busy), 16'h0000);
    chk("reset overrun", 16'(bus.Overrun), 16'h0000);
    chk("reset txerr", 16'(bus.Tx_Err), 16'h0000);
    bus.RdData_Valid  = 1'b0;
    bus.ALU_OUT_VALID = 1'b0;
    rst               = 1'b1;
    repeat (2) tick();
    chk("post-reset busy", 16'(bus.Resp_Busy), 16'h0000);
    chk("post-reset valid", 16'(bus.TX_DATA_VALID), 16'h0000);

    run_frame(1'b1, 8'hA5, 1'b0, 16'h0000, 0, 2, 4, 1'b0, -1, -1, "rd_a5");
    run_frame(1'b0, 8'h00, 1'b1, 16'h1234, 0, 3, 8, 1'b0, -1, -1, "alu_1234");
    run_frame(1'b1, 8'h11, 1'b1, 16'hBEEF, 0, 1, 2, 1'b0, -1, -1, "both");
    run_frame(1'b0, 8'h00, 1'b1, 16'h1234, 0, 1, 1, 1'b1, -1, -1, "timeout");
    run_frame(1'b0, 8'h00, 1'b1, 16'h1234, 0, 2, 3, 1'b0, -1, 6, "reset_hold");
    run_frame(1'b1, 8'h5A, 1'b0, 16'h0000, 6, 2, 3, 1'b0, -1, -1, "busy_at_strobe");
    run_frame(1'b0, 8'h00, 1'b1, 16'hC3E1, 0, 2, 5, 1'b0, 8, -1, "stray");

    for (int n = 0; n < 12; n++) begin
      kind = int'($urandom_range(0, 2));
      pre  = int'($urandom_range(0, 4));
      al   = int'($urandom_range(1, 5));
      bl   = int'($urandom_range(1, 10));
      na   = ($urandom_range(0, 7) == 0);
      st   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, HOLD - 1)) : -1;
      run_frame(kind != 1, 8'($urandom), kind != 0, 16'($urandom), pre, al, bl, na,
                st, -1, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
